// File: rtl/rob_pkg.sv
// Reorder buffer package: sizing constants, rename/redirect/commit bundles and ROB entry/state types.
package rob_pkg;

  localparam int unsigned Rwd    = 4;    // rename width
  localparam int unsigned Cwd    = 4;    // commit / walk width
  localparam int unsigned Wbwd   = 4;    // writeback ports
  localparam int unsigned RobSz  = 64;   // entries, power of two
  localparam int unsigned PrNum  = 128;  // physical registers
  localparam int unsigned RobIdW = $clog2(RobSz);
  localparam int unsigned PrW    = $clog2(PrNum);
  localparam int unsigned LrW    = 5;

  typedef logic [RobIdW-1:0] rob_id_t;
  typedef logic [RobIdW:0]   rob_cnt_t;

  typedef struct packed {
    logic [15:0]          opid;   // bit 15 = slot valid
    logic [LrW-1:0]       lrda;
    logic [1:0][PrW-1:0]  prda;   // [0] old mapping, [1] new mapping
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0] opid;            // bit 15 = redirect valid
    logic [7:0]  brid;            // bit 7 = snapshot available
    logic        rollback;
  } red_bundle_t;

  typedef struct packed {
    logic [15:0]          opid;
    logic [LrW-1:0]       lrda;
    logic [1:0][PrW-1:0]  prda;
  } com_bundle_t;

  typedef struct packed {
    logic [15:0]          opid;
    logic [LrW-1:0]       lrda;
    logic [1:0][PrW-1:0]  prda;
  } rob_entry_t;

  localparam int unsigned EntW = $bits(rob_entry_t);

  typedef enum logic {
    Normal,
    Walk
  } rob_state_t;

endpackage

// File: rtl/rob_mwpram.sv
// Multi-write, multi-read payload RAM with combinational read ports.
module rob_mwpram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 64,
  parameter int unsigned NumWr = 4,
  parameter int unsigned NumRd = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic                        clk,
  input  logic [NumWr-1:0]            we,
  input  logic [NumWr-1:0][Aw-1:0]    waddr,
  input  logic [NumWr-1:0][Width-1:0] wdata,
  input  logic [NumRd-1:0][Aw-1:0]    raddr,
  output logic [NumRd-1:0][Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  // Write all enabled ports; callers guarantee distinct addresses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumWr; i++) begin
      if (we[i]) mem_q[waddr[i]] <= wdata[i];
    end
  end

  // Asynchronous read of every port.
  always_comb begin
    for (int j = 0; j < NumRd; j++) rdata[j] = mem_q[raddr[j]];
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate from rename, out-of-order completion, in-order retire,
// youngest-first rollback walk on non-snapshot redirects.
// Optional macro ROB_WB_BYPASS_EN: a writeback to head+j counts as done for the same-cycle commit.
module rob
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  ren_bundle_t [Rwd-1:0]     ren_bundle,
  output logic [Rwd-1:0]            rename,
  output rob_id_t [Rwd-1:0]         rob_id,
  input  logic [Wbwd-1:0]           wb_valid,
  input  rob_id_t [Wbwd-1:0]        wb_id,
  input  red_bundle_t               red_bundle,
  input  rob_id_t                   red_robid,
  output logic                      rollback,
  output com_bundle_t [Cwd-1:0]     com_bundle,
  output rob_cnt_t                  count
);

  rob_state_t       state_q;
  rob_id_t          head_q, tail_q, walk_q, stop_q;
  rob_cnt_t         count_q;
  logic [RobSz-1:0] done_q;

  logic                     red_valid, red_snap;
  logic                     acc_run, com_run, walk_last;
  rob_cnt_t                 space;
  rob_id_t                  nacc, ncom, red_dist, sq_dist, stop_eff, walk_rem;
  logic [Wbwd-1:0]          wb_live;
  logic [Cwd-1:0]           head_done, com_vld;
  logic [Rwd-1:0][EntW-1:0] wr_data;
  rob_id_t [Cwd-1:0]        rd_addr;
  logic [Cwd-1:0][EntW-1:0] rd_data;
  logic                     unused_red;

  assign red_valid  = red_bundle.opid[15];
  assign red_snap   = red_bundle.brid[7];
  assign unused_red = ^{red_bundle.opid[14:0], red_bundle.brid[6:0], red_bundle.rollback};
  assign rollback   = (state_q == Walk);
  assign count      = count_q;

  rob_mwpram #(
    .Width (EntW),
    .Depth (RobSz),
    .NumWr (Rwd),
    .NumRd (Cwd)
  ) u_pram (
    .clk   (clk),
    .we    (rename),
    .waddr (rob_id),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Accept a contiguous prefix of valid slots that fits in the free space.
  always_comb begin
    rename  = '0;
    nacc    = '0;
    space   = rob_cnt_t'(RobSz) - count_q;
    acc_run = (state_q == Normal) && !red_valid;
    for (int i = 0; i < Rwd; i++) begin
      rob_id[i]  = tail_q + rob_id_t'(i);
      wr_data[i] = {ren_bundle[i].opid, ren_bundle[i].lrda, ren_bundle[i].prda};
      if (acc_run && ren_bundle[i].opid[15] && (rob_cnt_t'(i) < space)) begin
        rename[i] = 1'b1;
        nacc      = nacc + rob_id_t'(1);
      end else begin
        acc_run = 1'b0;
      end
    end
  end

  // Writebacks only land on entries between head and tail.
  always_comb begin
    for (int k = 0; k < Wbwd; k++) begin
      wb_live[k] = wb_valid[k] && (rob_cnt_t'(rob_id_t'(wb_id[k] - head_q)) < count_q);
    end
  end

  // Commit prefix in NORMAL, walk group in WALK; RAM read addresses follow the active sequence.
  always_comb begin
    com_vld   = '0;
    ncom      = '0;
    head_done = '0;
    red_dist  = red_robid - head_q;
    sq_dist   = tail_q - red_robid - rob_id_t'(1);
    stop_eff  = stop_q;
    // A redirect older than the current stop point retargets the walk.
    if ((state_q == Walk) && red_valid &&
        (rob_id_t'(red_robid - head_q) < rob_id_t'(stop_q - head_q))) begin
      stop_eff = red_robid;
    end
    walk_rem  = walk_q - stop_eff;
    walk_last = (walk_rem <= rob_id_t'(Cwd));
    for (int j = 0; j < Cwd; j++) begin
      rd_addr[j]   = (state_q == Walk) ? walk_q - rob_id_t'(j) : head_q + rob_id_t'(j);
      head_done[j] = done_q[head_q + rob_id_t'(j)];
`ifdef ROB_WB_BYPASS_EN
      for (int k = 0; k < Wbwd; k++) begin
        if (wb_valid[k] && (wb_id[k] == head_q + rob_id_t'(j))) head_done[j] = 1'b1;
      end
`endif
    end
    com_run = (state_q == Normal);
    for (int j = 0; j < Cwd; j++) begin
      if (state_q == Walk) begin
        com_vld[j] = (rob_id_t'(j) < walk_rem);
      end else if (com_run && (rob_cnt_t'(j) < count_q) && head_done[j] &&
                   (!red_valid || (rob_id_t'(j) <= red_dist))) begin
        com_vld[j] = 1'b1;
        ncom       = ncom + rob_id_t'(1);
      end else begin
        com_run = 1'b0;
      end
    end
  end

  // Invalid commit slots are driven to zero.
  always_comb begin
    for (int j = 0; j < Cwd; j++) begin
      com_bundle[j] = com_vld[j] ? com_bundle_t'(rd_data[j]) : '0;
    end
  end

  // Pointers, occupancy, done flags and the NORMAL/WALK state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Normal;
      head_q  <= '0;
      tail_q  <= '0;
      walk_q  <= '0;
      stop_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      for (int k = 0; k < Wbwd; k++) begin
        if (wb_live[k]) done_q[wb_id[k]] <= 1'b1;
      end
      // Allocation clears done after any stale writeback to the same slot.
      for (int i = 0; i < Rwd; i++) begin
        if (rename[i]) done_q[rob_id[i]] <= 1'b0;
      end
      unique case (state_q)
        Normal: begin
          head_q <= head_q + ncom;
          if (red_valid) begin
            if (red_snap) begin
              tail_q  <= red_robid + rob_id_t'(1);
              count_q <= count_q - rob_cnt_t'(ncom) - rob_cnt_t'(sq_dist);
            end else begin
              // Squashed entries stay counted until the walk finishes.
              count_q <= count_q - rob_cnt_t'(ncom);
              if (sq_dist != '0) begin
                walk_q  <= tail_q - rob_id_t'(1);
                stop_q  <= red_robid;
                state_q <= Walk;
              end
            end
          end else begin
            tail_q  <= tail_q + nacc;
            count_q <= count_q + rob_cnt_t'(nacc) - rob_cnt_t'(ncom);
          end
        end
        Walk: begin
          stop_q <= stop_eff;
          if (walk_last) begin
            tail_q  <= stop_eff + rob_id_t'(1);
            count_q <= count_q - rob_cnt_t'(rob_id_t'(tail_q - stop_eff - rob_id_t'(1)));
            state_q <= Normal;
          end else begin
            walk_q <= walk_q - rob_id_t'(Cwd);
          end
        end
        default: state_q <= Normal;
      endcase
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: stimulus pushes expected commit/rollback records, a negedge
// monitor pops and compares whenever a com_bundle slot is valid.
module tb_rob;
  import rob_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  ren_bundle_t [Rwd-1:0] ren_bundle;
  logic [Rwd-1:0]        rename;
  rob_id_t [Rwd-1:0]     rob_id;
  logic [Wbwd-1:0]       wb_valid;
  rob_id_t [Wbwd-1:0]    wb_id;
  red_bundle_t           red_bundle;
  rob_id_t               red_robid;
  logic                  rollback;
  com_bundle_t [Cwd-1:0] com_bundle;
  rob_cnt_t              count;

  always #5 clk = ~clk;

  rob dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ren_bundle (ren_bundle),
    .rename     (rename),
    .rob_id     (rob_id),
    .wb_valid   (wb_valid),
    .wb_id      (wb_id),
    .red_bundle (red_bundle),
    .red_robid  (red_robid),
    .rollback   (rollback),
    .com_bundle (com_bundle),
    .count      (count)
  );

  typedef struct packed {
    logic        rb;
    com_bundle_t com;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tag_ctr = 0;
  int         tb_tail = 0;
  logic [7:0] ent_tag [RobSz];

  function automatic ren_bundle_t mk_op(logic [7:0] tag);
    ren_bundle_t r;
    r         = '0;
    r.opid    = {1'b1, 7'd0, tag};
    r.lrda    = tag[4:0];
    r.prda[1] = tag[6:0];
    r.prda[0] = tag[6:0] ^ 7'h2a;
    return r;
  endfunction

  function automatic com_bundle_t exp_com(logic [7:0] tag);
    com_bundle_t c;
    c         = '0;
    c.opid    = {1'b1, 7'd0, tag};
    c.lrda    = tag[4:0];
    c.prda[1] = tag[6:0];
    c.prda[0] = tag[6:0] ^ 7'h2a;
    return c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_com(logic rb, int id);
    exp_t e;
    e.rb  = rb;
    e.com = exp_com(ent_tag[id]);
    sb_q.push_back(e);
  endtask

  task automatic idle_in();
    ren_bundle = '0;
    wb_valid   = '0;
    wb_id      = '0;
    red_bundle = '0;
    red_robid  = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    tb_tail = 0;
  endtask

  // Present n valid slots, expect all accepted, then advance one cycle.
  task automatic accept(int n);
    for (int i = 0; i < Rwd; i++) begin
      ren_bundle[i] = (i < n) ? mk_op(8'(tag_ctr + i)) : ren_bundle_t'('0);
    end
    @(negedge clk);
    chk("acc_rename", 64'(rename), 64'((1 << n) - 1));
    for (int i = 0; i < n; i++) ent_tag[(tb_tail + i) % RobSz] = 8'(tag_ctr + i);
    tb_tail = (tb_tail + n) % RobSz;
    tag_ctr = tag_ctr + n;
    next_cyc();
    ren_bundle = '0;
  endtask

  task automatic redirect(logic snap, int robid);
    red_bundle.opid = 16'h8000;
    red_bundle.brid = snap ? 8'h80 : 8'h00;
    red_robid       = rob_id_t'(robid);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int j = 0; j < Cwd; j++) begin
        if (com_bundle[j].opid[15] === 1'b1) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected slot %0d: got %0h expected none", j,
                     {rollback, com_bundle[j]});
          end else begin
            mon_e = sb_q.pop_front();
            if ({rollback, com_bundle[j]} !== mon_e) begin
              n_fail++;
              $display("FAIL sb_com slot %0d: got %0h expected %0h", j,
                       {rollback, com_bundle[j]}, mon_e);
            end
          end
        end
      end
    end
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    #2;
    chk("rst_rename", 64'(rename), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rollback", 64'(rollback), 64'd0);
    chk("rst_com", 64'(|com_bundle), 64'd0);
    do_reset();

    // Four slots accepted at ids 0..3.
    for (int i = 0; i < Rwd; i++) ren_bundle[i] = mk_op(8'(tag_ctr + i));
    @(negedge clk);
    chk("s1_rename", 64'(rename), 64'hf);
    for (int i = 0; i < Rwd; i++) chk("s1_rob_id", 64'(rob_id[i]), 64'(i));
    for (int i = 0; i < Rwd; i++) ent_tag[i] = 8'(tag_ctr + i);
    tb_tail = 4;
    tag_ctr = tag_ctr + 4;
    next_cyc();
    ren_bundle = '0;
    @(negedge clk);
    chk("s1_count", 64'(count), 64'd4);

    // Writeback 0,1,3: only 0,1 retire.
    next_cyc();
    wb_valid = 4'b0111;
    wb_id[0] = 6'd0;
    wb_id[1] = 6'd1;
    wb_id[2] = 6'd3;
    expect_com(1'b0, 0);
    expect_com(1'b0, 1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("s2_count_during", 64'(count), 64'd4);
    next_cyc();
    @(negedge clk);
    chk("s2_count_after", 64'(count), 64'd2);
    // Head is at 2: completing 2 releases 2 and 3.
    next_cyc();
    wb_valid[0] = 1'b1;
    wb_id[0]    = 6'd2;
    expect_com(1'b0, 2);
    expect_com(1'b0, 3);
    next_cyc();
    idle_in();
    next_cyc();
    @(negedge clk);
    chk("s2_count_empty", 64'(count), 64'd0);

    // Fill to 64, retire two, accept two at ids 0,1 through the wrap.
    next_cyc();
    do_reset();
    for (int c = 0; c < RobSz / Rwd; c++) accept(Rwd);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd64);
    next_cyc();
    for (int i = 0; i < Rwd; i++) ren_bundle[i] = mk_op(8'(tag_ctr + i));
    wb_valid = 4'b0011;
    wb_id[0] = 6'd0;
    wb_id[1] = 6'd1;
    expect_com(1'b0, 0);
    expect_com(1'b0, 1);
    @(negedge clk);
    chk("full_rename", 64'(rename), 64'd0);
    next_cyc();
    wb_valid = '0;
    @(negedge clk);
    chk("full_rename_commit", 64'(rename), 64'd0);
    next_cyc();
    @(negedge clk);
    chk("wrap_rename", 64'(rename), 64'h3);
    chk("wrap_rob_id0", 64'(rob_id[0]), 64'd0);
    chk("wrap_rob_id1", 64'(rob_id[1]), 64'd1);
    tag_ctr = tag_ctr + 4;
    next_cyc();
    ren_bundle = '0;
    @(negedge clk);
    chk("wrap_count", 64'(count), 64'd64);

    // Non-snapshot redirect at 3 with ids 0..9 live: walk 9,8,7,6 then 5,4.
    next_cyc();
    do_reset();
    accept(4);
    accept(4);
    accept(2);
    redirect(1'b0, 3);
    ren_bundle[0] = mk_op(8'(tag_ctr));
    for (int id = 9; id >= 4; id--) expect_com(1'b1, id);
    @(negedge clk);
    chk("red_rename_blocked", 64'(rename), 64'd0);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("walk1_rollback", 64'(rollback), 64'd1);
    next_cyc();
    @(negedge clk);
    chk("walk2_rollback", 64'(rollback), 64'd1);
    next_cyc();
    @(negedge clk);
    chk("walk_end_rollback", 64'(rollback), 64'd0);
    chk("walk_end_count", 64'(count), 64'd4);
    next_cyc();
    ren_bundle[0] = mk_op(8'(tag_ctr));
    tag_ctr++;
    @(negedge clk);
    chk("walk_tail_rename", 64'(rename), 64'h1);
    chk("walk_tail_id", 64'(rob_id[0]), 64'd4);
    next_cyc();
    idle_in();

    // Snapshot redirect: no walk, tail restored in one cycle.
    do_reset();
    accept(4);
    accept(4);
    accept(2);
    redirect(1'b1, 3);
    @(negedge clk);
    chk("snap_red_rollback", 64'(rollback), 64'd0);
    next_cyc();
    idle_in();
    ren_bundle[0] = mk_op(8'(tag_ctr));
    tag_ctr++;
    @(negedge clk);
    chk("snap_rollback", 64'(rollback), 64'd0);
    chk("snap_count", 64'(count), 64'd4);
    chk("snap_rename", 64'(rename), 64'h1);
    chk("snap_tail_id", 64'(rob_id[0]), 64'd4);
    next_cyc();
    idle_in();

    // Reset asserted in the middle of a walk.
    do_reset();
    accept(4);
    accept(4);
    accept(2);
    redirect(1'b0, 3);
    for (int id = 9; id >= 6; id--) expect_com(1'b1, id);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("midwalk_rollback", 64'(rollback), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_walk_rollback", 64'(rollback), 64'd0);
    chk("rst_walk_count", 64'(count), 64'd0);
    chk("rst_walk_com", 64'(|com_bundle), 64'd0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
